// File: rtl/adc_meas_scheduler_if.sv
// Handshake bundle between the measurement scheduler, the button edge detectors,
// the ADC front end and the display path.
interface adc_meas_scheduler_if;
  logic        hold_tick;
  logic        release_tick;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        adc_start;
  logic [11:0] display_value;
  logic        average_enable;
  logic        LED_hold;
  logic        LED_average;
  logic        adc_timeout_err;

  // scheduler side
  modport master (
    input  hold_tick, release_tick, adc_done, adc_data,
    output adc_start, display_value, average_enable, LED_hold, LED_average, adc_timeout_err
  );

  // environment side: buttons, ADC and display
  modport slave (
    output hold_tick, release_tick, adc_done, adc_data,
    input  adc_start, display_value, average_enable, LED_hold, LED_average, adc_timeout_err
  );
endinterface

// File: rtl/adc_meas_scheduler.sv
// Voltmeter ADC sequencer: periodic conversions, hold freeze and burst averaging
// after a configurable number of hold presses.
module adc_meas_scheduler #(
  parameter int SAMPLE_DIV   = 50000,
  parameter int AVG_LOG2     = 2,
  parameter int HOLDS_TO_AVG = 4,
  parameter int TIMEOUT      = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  adc_meas_scheduler_if.master bus
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int HW = $clog2(HOLDS_TO_AVG + 1);
  localparam int BW = AVG_LOG2 + 1;
  localparam int AW = 12 + AVG_LOG2;
  localparam int NS = 1 << AVG_LOG2;

  typedef enum logic [2:0] {MEAS, CONV, HOLD, BSTART, BWAIT, AVERAGE} state_t;

  state_t        state;
  logic [TW-1:0] tmr;
  logic [WW-1:0] wcnt;
  logic [HW-1:0] hcnt;
  logic [BW-1:0] bcnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic [HW-1:0] hold_nxt;
  logic          pend;
  logic          tc;
  logic          wait_exp;

  always_comb begin
    tc       = (tmr == TW'(SAMPLE_DIV - 1));
    wait_exp = (wcnt == WW'(TIMEOUT - 1));
    acc_sum  = acc + AW'(bus.adc_data);
    hold_nxt = hcnt + 1'b1;
  end

  // sample timer never stops, so periodic sampling realigns to the same grid after hold/average
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  tmr <= '0;
    else if (tc) tmr <= '0;
    else         tmr <= tmr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= MEAS;
      wcnt                <= '0;
      hcnt                <= '0;
      bcnt                <= '0;
      acc                 <= '0;
      pend                <= 1'b0;
      bus.adc_start       <= 1'b0;
      bus.display_value   <= '0;
      bus.average_enable  <= 1'b0;
      bus.LED_hold        <= 1'b0;
      bus.LED_average     <= 1'b0;
      bus.adc_timeout_err <= 1'b0;
    end else begin
      bus.adc_start <= 1'b0;
      case (state)
        MEAS: begin
          // a pending hold beats a coincident terminal count
          if (pend || bus.hold_tick) begin
            pend <= 1'b0;
            if (hold_nxt == HW'(HOLDS_TO_AVG)) begin
              hcnt  <= '0;
              acc   <= '0;
              bcnt  <= '0;
              state <= BSTART;
            end else begin
              hcnt         <= hold_nxt;
              bus.LED_hold <= 1'b1;
              state        <= HOLD;
            end
          end else if (tc) begin
            bus.adc_start <= 1'b1;
            wcnt          <= '0;
            state         <= CONV;
          end
        end
        CONV: begin
          if (bus.hold_tick) pend <= 1'b1;
          if (bus.adc_done) begin
            bus.display_value <= bus.adc_data;
            state             <= MEAS;
          end else if (wait_exp) begin
            bus.adc_timeout_err <= 1'b1;
            state               <= MEAS;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.release_tick) begin
            bus.LED_hold <= 1'b0;
            state        <= MEAS;
          end
        end
        BSTART: begin
          bus.adc_start <= 1'b1;
          wcnt          <= '0;
          state         <= BWAIT;
        end
        BWAIT: begin
          if (bus.adc_done) begin
            if (bcnt == BW'(NS - 1)) begin
              bus.display_value  <= acc_sum[AW-1:AVG_LOG2];
              bus.average_enable <= 1'b1;
              bus.LED_average    <= 1'b1;
              state              <= AVERAGE;
            end else begin
              acc   <= acc_sum;
              bcnt  <= bcnt + 1'b1;
              state <= BSTART;
            end
          end else if (wait_exp) begin
            bus.adc_timeout_err <= 1'b1;
            bus.average_enable  <= 1'b0;
            state               <= MEAS;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        AVERAGE: begin
          if (bus.release_tick) begin
            bus.average_enable <= 1'b0;
            bus.LED_average    <= 1'b0;
            state              <= MEAS;
          end
        end
        default: state <= MEAS;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_meas_scheduler.sv
// Scoreboard bench: the ADC model pushes the expected display value for every
// reply it drives; the monitor pops and compares one cycle after adc_done.
module tb_adc_meas_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_meas_scheduler_if bus();

  adc_meas_scheduler #(
    .SAMPLE_DIV(10), .AVG_LOG2(2), .HOLDS_TO_AVG(4), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int data_q[$], expd_q[$], sb_q[$];
  logic [11:0] def_data = 12'h123;
  bit adc_en = 1'b1;
  bit flush  = 1'b0;
  bit stray  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ADC model: replies 3 cycles after adc_start, data from data_q else def_data
  initial begin
    int cd;
    int d, e;
    cd = 0;
    bus.adc_done = 1'b0;
    bus.adc_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.adc_done = 1'b0;
      if (flush) begin
        cd = 0;
        data_q.delete();
        expd_q.delete();
      end else if (stray) begin
        bus.adc_data = 12'hABC;
        bus.adc_done = 1'b1;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            if (data_q.size() > 0) begin
              d = data_q.pop_front();
              e = expd_q.pop_front();
            end else begin
              d = int'(def_data);
              e = int'(def_data);
            end
            bus.adc_data = d[11:0];
            bus.adc_done = 1'b1;
            sb_q.push_back(e);
          end
        end
        if (bus.adc_start && adc_en) cd = 3;
      end
    end
  end

  // monitor: counts start cycles and checks display one cycle after each reply
  initial begin
    bit pend;
    int e;
    pend = 1'b0;
    e = -1;
    forever begin
      @(negedge clk);
      if (bus.adc_start) start_cnt++;
      if (pend) begin
        pend = 1'b0;
        if (e >= 0) chk("sb_display", 32'(bus.display_value), 32'(e));
      end
      if (bus.adc_done && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        pend = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_start(input int maxc, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.adc_start && n < maxc);
    if (!bus.adc_start) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.adc_done && n < maxc);
    if (!bus.adc_done) chk(tag, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_avg(input int maxc, input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.average_enable && n < maxc);
    if (!bus.average_enable) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic hold_pulse();
    bus.hold_tick = 1'b1;
    @(negedge clk);
    bus.hold_tick = 1'b0;
  endtask

  task automatic release_pulse();
    bus.release_tick = 1'b1;
    @(negedge clk);
    bus.release_tick = 1'b0;
  endtask

  task automatic hold_release(input string tag);
    wait_done(30, {tag, "_done"});
    hold_pulse();
    chk({tag, "_led"}, 32'(bus.LED_hold), 32'd1);
    release_pulse();
    chk({tag, "_led_off"}, 32'(bus.LED_hold), 32'd0);
  endtask

  initial begin
    realtime t1;
    int s0;
    bus.hold_tick = 1'b0;
    bus.release_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(bus.adc_start), 32'd0);
    chk("rst_disp", 32'(bus.display_value), 32'd0);
    chk("rst_avg", 32'(bus.average_enable), 32'd0);
    chk("rst_lhold", 32'(bus.LED_hold), 32'd0);
    chk("rst_lavg", 32'(bus.LED_average), 32'd0);
    chk("rst_err", 32'(bus.adc_timeout_err), 32'd0);
    rst_n = 1'b1;

    // periodic sampling
    wait_start(20, "start0");
    t1 = $realtime;
    @(negedge clk);
    chk("start_width", 32'(bus.adc_start), 32'd0);
    wait_done(10, "done0");
    wait_start(20, "start1");
    chk("period", 32'(int'(($realtime - t1) / 10.0)), 32'd10);
    wait_done(10, "done1");

    // hold freezes the display and stops conversions
    hold_pulse();
    chk("led_hold", 32'(bus.LED_hold), 32'd1);
    def_data = 12'h456;
    s0 = start_cnt;
    repeat (30) @(negedge clk);
    chk("hold_nostart", 32'(start_cnt - s0), 32'd0);
    chk("hold_frozen", 32'(bus.display_value), 32'h123);
    release_pulse();
    chk("led_hold_off", 32'(bus.LED_hold), 32'd0);
    wait_start(20, "resume");
    wait_done(10, "resume_done");
    hold_release("h2");
    hold_release("h3");

    // 4th press: burst average
    wait_done(30, "b1_pre");
    data_q = '{100, 200, 300, 401};
    expd_q = '{-1, -1, -1, 250};
    s0 = start_cnt;
    hold_pulse();
    wait_avg(80, "b1_avg");
    chk("b1_disp", 32'(bus.display_value), 32'd250);
    chk("b1_lavg", 32'(bus.LED_average), 32'd1);
    chk("b1_starts", 32'(start_cnt - s0), 32'd4);
    repeat (20) @(negedge clk);
    chk("avg_nostart", 32'(start_cnt - s0), 32'd4);
    chk("avg_frozen", 32'(bus.display_value), 32'd250);
    release_pulse();
    chk("b1_avg_off", 32'(bus.average_enable), 32'd0);
    chk("b1_lavg_off", 32'(bus.LED_average), 32'd0);
    wait_start(20, "b1_meas");

    // full-scale burst
    hold_release("h5");
    hold_release("h6");
    hold_release("h7");
    wait_done(30, "b2_pre");
    data_q = '{4095, 4095, 4095, 4095};
    expd_q = '{-1, -1, -1, 4095};
    hold_pulse();
    wait_avg(80, "b2_avg");
    chk("b2_disp", 32'(bus.display_value), 32'hFFF);
    release_pulse();

    // hold during a conversion: new sample shown, then HOLD
    def_data = 12'h789;
    wait_start(20, "hc_start");
    hold_pulse();
    wait_done(10, "hc_done");
    @(negedge clk);
    chk("hc_led", 32'(bus.LED_hold), 32'd1);
    chk("hc_disp", 32'(bus.display_value), 32'h789);
    release_pulse();

    // timeout
    adc_en = 1'b0;
    wait_start(20, "to_start");
    repeat (19) @(negedge clk);
    chk("to_err_early", 32'(bus.adc_timeout_err), 32'd0);
    @(negedge clk);
    chk("to_err", 32'(bus.adc_timeout_err), 32'd1);
    chk("to_disp", 32'(bus.display_value), 32'h789);
    wait_start(12, "to_retry");
    adc_en = 1'b1;
    repeat (25) @(negedge clk);
    chk("err_sticky", 32'(bus.adc_timeout_err), 32'd1);

    // reset mid-burst, then a stray done
    hold_release("h9");
    hold_release("h10");
    wait_done(30, "b3_pre");
    data_q = '{10, 20, 30, 40};
    expd_q = '{-1, -1, -1, 25};
    hold_pulse();
    wait_done(20, "b3_d1");
    wait_done(20, "b3_d2");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_start", 32'(bus.adc_start), 32'd0);
    chk("arst_disp", 32'(bus.display_value), 32'd0);
    chk("arst_avg", 32'(bus.average_enable), 32'd0);
    chk("arst_err", 32'(bus.adc_timeout_err), 32'd0);
    flush = 1'b1;
    sb_q.delete();
    repeat (2) @(negedge clk);
    flush = 1'b0;
    sb_q.delete();
    rst_n = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_disp", 32'(bus.display_value), 32'd0);
    chk("stray_avg", 32'(bus.average_enable), 32'd0);
    chk("stray_lavg", 32'(bus.LED_average), 32'd0);
    wait_start(20, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_meas_scheduler.md
Name: adc_meas_scheduler

Overview:
Controller that sequences the voltmeter's ADC datapath. It issues periodic conversion requests to the ADC over a start/done handshake and latches each result. It also runs the hold / average user modes from the hold and release tick pulses, replacing free-running accumulation with scheduled burst sampling for averages. Sits between the button edge detectors, the ADC interface and the BCD/7-seg display path.

Parameters:
SAMPLE_DIV, 50000, clk cycles between periodic conversion requests (>=2)
AVG_LOG2, 2, log2 of samples per average burst (burst = 2^AVG_LOG2)
HOLDS_TO_AVG, 4, number of hold presses that triggers an average burst (>=1)
TIMEOUT, 255, max clk cycles waiting for adc_done before abort

Ports:
clk  in  1  system clock from PLL
rst_n  in  1  asynchronous active-low reset
hold_tick  in  1  one-cycle pulse from hold edge detector
release_tick  in  1  one-cycle pulse from release edge detector
adc_done  in  1  one-cycle pulse; adc_data valid in the same cycle
adc_data  in  12  conversion result
adc_start  out  1  one-cycle conversion request
display_value  out  12  value for display path
average_enable  out  1  high while display_value holds an average
LED_hold  out  1  high in HOLD
LED_average  out  1  high in AVERAGE
adc_timeout_err  out  1  sticky flag: a conversion timed out

Behaviour:
- Reset (async, rst_n=0): state MEAS; all outputs 0; sample timer, hold counter, burst counter, accumulator and pending flag cleared.
- Sample timer: free-runs 0..SAMPLE_DIV-1 in every state and wraps; terminal count = value SAMPLE_DIV-1.
- MEAS: at timer terminal count, assert adc_start for exactly one cycle and go to CONV. On hold_tick, store the hold-pending flag.
- CONV: wait for adc_done. On adc_done, display_value <= adc_data on the next edge, then return to MEAS.
  - If no adc_done within TIMEOUT cycles after adc_start: set adc_timeout_err, keep display_value unchanged, return to MEAS.
  - A hold_tick while in CONV sets the pending flag.
- Hold decision (MEAS, pending flag set or hold_tick present):
  - Clear the pending flag and increment the hold counter.
  - If the incremented count equals HOLDS_TO_AVG: reset the counter to 0 and go to BURST.
  - Otherwise go to HOLD with LED_hold=1.
  - The pending flag is checked before the timer terminal count; hold wins if both occur in the same cycle.
- HOLD: display_value frozen; no conversions. On release_tick: LED_hold=0, go to MEAS. hold_tick is ignored.
- BURST: issue 2^AVG_LOG2 conversions back-to-back.
  - Pulse adc_start one cycle after entry and one cycle after each adc_done; the sample timer is ignored.
  - Accumulator is 12+AVG_LOG2 bits, cleared on entry; each adc_data is added without overflow.
  - After the last sample: display_value <= acc >> AVG_LOG2 (truncating); average_enable=1, LED_average=1; go to AVERAGE.
  - On a timeout during BURST: set adc_timeout_err, discard the burst, go to MEAS with average_enable=0.
  - release_tick during BURST is ignored.
- AVERAGE: display_value frozen. On release_tick: average_enable=0, LED_average=0, go to MEAS. hold_tick is ignored.
- Outputs are registered. adc_start goes high one edge after the triggering condition is seen.
- adc_done outside CONV/BURST wait is ignored.
- adc_timeout_err clears only on reset.
- Reset mid-conversion or mid-burst: immediate return to reset values. A later late adc_done is ignored.

Test Plan:
- SAMPLE_DIV=10, ADC model replies adc_done 3 cycles after start with data 0x123 -> adc_start pulses every 10 cycles; display_value=0x123 after the first done.
- hold_tick in MEAS -> LED_hold=1; adc_start stays low; display_value frozen despite ADC data changing to 0x456. release_tick -> LED_hold=0, periodic sampling resumes.
- 4th hold press, burst data 100, 200, 300, 401 -> exactly 4 adc_start pulses, display_value=250, average_enable=1, LED_average=1. release_tick -> both 0, state MEAS.
- Burst data all 0xFFF -> display_value=0xFFF (no overflow in 14-bit acc).
- ADC model never asserts done, TIMEOUT=20 -> adc_timeout_err=1 at cycle 20 after start, display_value unchanged, sampling retries on the next terminal count.
- hold_tick during CONV -> enters HOLD right after adc_done, showing the new sample. rst_n low mid-burst -> all outputs 0 asynchronously; a subsequent stray adc_done has no effect.
